// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: decode -> execute pipeline register.
//   Holds every field the execute stage needs for one instruction. It also owns
//   the {Z,C,N,V} status register, which is written from the ALU status output.
//   The C flag is returned to the ALU as ex_carry.
// Ports:
//   clk, rst_n        : rising-edge clock, async active-low reset
//   stall, flush      : hold stage / insert bubble (flush wins)
//   id_*              : decode-stage fields for the incoming instruction
//   ex_*              : registered copies of id_* for the execute stage
//   alu_sr            : ALU status {Z,C,N,V} for the instruction now in EX
//   sr, ex_carry      : architectural status register and its C bit
// Optional feature (macro ID_EX_BUBBLE_CNT_EN):
//   bubble_cnt        : saturating count of bubbles entering EX
module id_ex_stage_reg #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic          id_wb_en,
  input  logic          id_mem_r_en,
  input  logic          id_mem_w_en,
  input  logic          id_b,
  input  logic          id_s,
  input  logic          id_imm,
  input  logic [3:0]    id_exe_cmd,
  input  logic [DW-1:0] id_pc,
  input  logic [DW-1:0] id_val_rn,
  input  logic [DW-1:0] id_val_rm,
  input  logic [11:0]   id_shift_operand,
  input  logic [23:0]   id_imm24,
  input  logic [3:0]    id_dest,
  output logic          ex_valid,
  output logic          ex_wb_en,
  output logic          ex_mem_r_en,
  output logic          ex_mem_w_en,
  output logic          ex_b,
  output logic          ex_s,
  output logic          ex_imm,
  output logic [3:0]    ex_exe_cmd,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_val_rn,
  output logic [DW-1:0] ex_val_rm,
  output logic [11:0]   ex_shift_operand,
  output logic [23:0]   ex_imm24,
  output logic [3:0]    ex_dest,
  input  logic [3:0]    alu_sr,
  output logic [3:0]    sr,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic [15:0]   bubble_cnt,
`endif
  output logic          ex_carry
);

  typedef struct packed {
    logic          valid;
    logic          wb_en;
    logic          mem_r_en;
    logic          mem_w_en;
    logic          b;
    logic          s;
    logic          imm;
    logic [3:0]    exe_cmd;
    logic [DW-1:0] pc;
    logic [DW-1:0] val_rn;
    logic [DW-1:0] val_rm;
    logic [11:0]   shift_operand;
    logic [23:0]   imm24;
    logic [3:0]    dest;
  } stage_t;

  stage_t     id_pkt;
  stage_t     stage_d, stage_q;
  logic [3:0] sr_d, sr_q;

  always_comb begin
    id_pkt.valid         = id_valid;
    id_pkt.wb_en         = id_wb_en;
    id_pkt.mem_r_en      = id_mem_r_en;
    id_pkt.mem_w_en      = id_mem_w_en;
    id_pkt.b             = id_b;
    id_pkt.s             = id_s;
    id_pkt.imm           = id_imm;
    id_pkt.exe_cmd       = id_exe_cmd;
    id_pkt.pc            = id_pc;
    id_pkt.val_rn        = id_val_rn;
    id_pkt.val_rm        = id_val_rm;
    id_pkt.shift_operand = id_shift_operand;
    id_pkt.imm24         = id_imm24;
    id_pkt.dest          = id_dest;
  end

  // Flush has priority over stall; a bubble clears data fields as well as controls.
  always_comb begin
    stage_d = id_pkt;
    if (flush)      stage_d = '0;
    else if (stall) stage_d = stage_q;
  end

  // Flags commit when the S-instruction leaves EX. A flush only replaces the
  // incoming instruction, so it does not block this write.
  always_comb begin
    sr_d = sr_q;
    if (stage_q.valid && stage_q.s && !stall) sr_d = alu_sr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      sr_q    <= '0;
    end else begin
      stage_q <= stage_d;
      sr_q    <= sr_d;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_d, bubble_cnt_q;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if ((flush || (!stall && !id_valid)) && bubble_cnt_q != 16'hFFFF)
      bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bubble_cnt_q <= '0;
    else        bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

  assign ex_valid         = stage_q.valid;
  assign ex_wb_en         = stage_q.wb_en;
  assign ex_mem_r_en      = stage_q.mem_r_en;
  assign ex_mem_w_en      = stage_q.mem_w_en;
  assign ex_b             = stage_q.b;
  assign ex_s             = stage_q.s;
  assign ex_imm           = stage_q.imm;
  assign ex_exe_cmd       = stage_q.exe_cmd;
  assign ex_pc            = stage_q.pc;
  assign ex_val_rn        = stage_q.val_rn;
  assign ex_val_rm        = stage_q.val_rm;
  assign ex_shift_operand = stage_q.shift_operand;
  assign ex_imm24         = stage_q.imm24;
  assign ex_dest          = stage_q.dest;
  assign sr               = sr_q;
  assign ex_carry         = sr_q[2];

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;
  logic        clk = 0, rst_n = 1, stall = 0, flush = 0;
  logic        id_valid = 0, id_wb_en = 0, id_mem_r_en = 0, id_mem_w_en = 0;
  logic        id_b = 0, id_s = 0, id_imm = 0;
  logic [3:0]  id_exe_cmd = 0, id_dest = 0, alu_sr = 0;
  logic [31:0] id_pc = 0, id_val_rn = 0, id_val_rm = 0;
  logic [11:0] id_shift_operand = 0;
  logic [23:0] id_imm24 = 0;
  logic        ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm, ex_carry;
  logic [3:0]  ex_exe_cmd, ex_dest, sr;
  logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
  logic [11:0] ex_shift_operand;
  logic [23:0] ex_imm24;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_mem_w_en(id_mem_w_en), .id_b(id_b), .id_s(id_s), .id_imm(id_imm),
    .id_exe_cmd(id_exe_cmd), .id_pc(id_pc), .id_val_rn(id_val_rn),
    .id_val_rm(id_val_rm), .id_shift_operand(id_shift_operand),
    .id_imm24(id_imm24), .id_dest(id_dest),
    .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
    .ex_mem_w_en(ex_mem_w_en), .ex_b(ex_b), .ex_s(ex_s), .ex_imm(ex_imm),
    .ex_exe_cmd(ex_exe_cmd), .ex_pc(ex_pc), .ex_val_rn(ex_val_rn),
    .ex_val_rm(ex_val_rm), .ex_shift_operand(ex_shift_operand),
    .ex_imm24(ex_imm24), .ex_dest(ex_dest),
    .alu_sr(alu_sr), .sr(sr),
`ifdef ID_EX_BUBBLE_CNT_EN
    .bubble_cnt(bubble_cnt),
`endif
    .ex_carry(ex_carry)
  );

  typedef struct {
    logic        flush, stall, valid, s;
    logic [3:0]  cmd;
    logic [31:0] pc, rn;
    logic [3:0]  alu;
    logic        e_valid, e_s;
    logic [3:0]  e_cmd;
    logic [31:0] e_pc, e_rn;
    logic [3:0]  e_sr;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Secondary id fields are derived from the primary ones; every mapping sends 0 to 0
  // so a bubble's expected side fields are also all zero.
  function automatic logic [76:0] side(input logic v, input logic [3:0] c,
                                       input logic [31:0] p, input logic [31:0] r);
    return {v, c[0], c[1], c[3], c[2], c, {r[15:0], r[31:16]}, p[11:0], r[23:0]};
  endfunction

  task automatic drive(input logic f, input logic st, input logic v, input logic s,
                       input logic [3:0] c, input logic [31:0] p, input logic [31:0] r,
                       input logic [3:0] a);
    flush = f; stall = st; id_valid = v; id_s = s; id_exe_cmd = c; id_pc = p;
    id_val_rn = r; alu_sr = a;
    id_wb_en = v; id_mem_r_en = c[0]; id_mem_w_en = c[1]; id_b = c[3]; id_imm = c[2];
    id_dest = c; id_val_rm = {r[15:0], r[31:16]}; id_shift_operand = p[11:0];
    id_imm24 = r[23:0];
  endtask

  function automatic logic [76:0] act_side();
    return {ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_imm, ex_dest, ex_val_rm,
            ex_shift_operand, ex_imm24};
  endfunction

  initial begin
    //          fl st v  s  cmd    pc     rn            alu  | v  s  cmd   pc     rn            sr
    vt[0]  = '{0, 0, 1, 0, 4'h2, 32'h10, 32'hA5A5A5A5, 4'hF, 1, 0, 4'h2, 32'h10, 32'hA5A5A5A5, 4'h0};
    vt[1]  = '{0, 1, 1, 1, 4'h4, 32'h20, 32'h1,        4'hF, 1, 0, 4'h2, 32'h10, 32'hA5A5A5A5, 4'h0};
    vt[2]  = '{0, 1, 1, 1, 4'h4, 32'h20, 32'h1,        4'hF, 1, 0, 4'h2, 32'h10, 32'hA5A5A5A5, 4'h0};
    vt[3]  = '{0, 1, 1, 1, 4'h4, 32'h20, 32'h1,        4'hF, 1, 0, 4'h2, 32'h10, 32'hA5A5A5A5, 4'h0};
    vt[4]  = '{0, 0, 1, 1, 4'h9, 32'h24, 32'h1,        4'hF, 1, 1, 4'h9, 32'h24, 32'h1,        4'h0};
    vt[5]  = '{0, 0, 1, 0, 4'h3, 32'h28, 32'h2,        4'h4, 1, 0, 4'h3, 32'h28, 32'h2,        4'h4};
    vt[6]  = '{0, 0, 1, 1, 4'hF, 32'h2C, 32'h3,        4'h8, 1, 1, 4'hF, 32'h2C, 32'h3,        4'h4};
    vt[7]  = '{0, 1, 1, 0, 4'h5, 32'h30, 32'h4,        4'h1, 1, 1, 4'hF, 32'h2C, 32'h3,        4'h4};
    vt[8]  = '{0, 1, 1, 0, 4'h5, 32'h30, 32'h4,        4'h1, 1, 1, 4'hF, 32'h2C, 32'h3,        4'h4};
    vt[9]  = '{0, 0, 1, 0, 4'h5, 32'h30, 32'h4,        4'h1, 1, 0, 4'h5, 32'h30, 32'h4,        4'h1};
    vt[10] = '{1, 1, 1, 1, 4'h4, 32'h34, 32'h5,        4'hF, 0, 0, 4'h0, 32'h0,  32'h0,        4'h1};
    vt[11] = '{0, 0, 0, 0, 4'h6, 32'h38, 32'h6,        4'hF, 0, 0, 4'h6, 32'h38, 32'h6,        4'h1};
    vt[12] = '{0, 0, 1, 1, 4'h1, 32'h3C, 32'h7,        4'hF, 1, 1, 4'h1, 32'h3C, 32'h7,        4'h1};
    vt[13] = '{1, 0, 1, 1, 4'h2, 32'h40, 32'h8,        4'h6, 0, 0, 4'h0, 32'h0,  32'h0,        4'h6};
    vt[14] = '{0, 0, 1, 0, 4'hE, 32'h44, 32'h9,        4'h0, 1, 0, 4'hE, 32'h44, 32'h9,        4'h6};

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    #2 rst_n = 0;
    #1;
    chk("reset_ctrl", {ex_valid, ex_s, ex_exe_cmd}, 0);
    chk("reset_data", {ex_pc, ex_val_rn}, 0);
    chk("reset_side", act_side(), 0);
    chk("reset_sr", {sr, ex_carry}, 0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].flush, vt[i].stall, vt[i].valid, vt[i].s, vt[i].cmd, vt[i].pc,
            vt[i].rn, vt[i].alu);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), ex_valid, vt[i].e_valid);
      chk($sformatf("v%0d_s", i), ex_s, vt[i].e_s);
      chk($sformatf("v%0d_cmd", i), ex_exe_cmd, vt[i].e_cmd);
      chk($sformatf("v%0d_pc", i), ex_pc, vt[i].e_pc);
      chk($sformatf("v%0d_rn", i), ex_val_rn, vt[i].e_rn);
      chk($sformatf("v%0d_side", i), act_side(),
          side(vt[i].e_valid, vt[i].e_cmd, vt[i].e_pc, vt[i].e_rn));
      chk($sformatf("v%0d_sr", i), sr, vt[i].e_sr);
      chk($sformatf("v%0d_carry", i), ex_carry, vt[i].e_sr[2]);
    end

    // Reset during a stall discards the held instruction and the flags.
    drive(0, 1, 1, 1, 4'h7, 32'h50, 32'hB, 4'hF);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_stall_pc", ex_pc, 0);
    chk("rst_stall_ctrl", {ex_valid, ex_s, ex_exe_cmd}, 0);
    chk("rst_stall_sr", {sr, ex_carry}, 0);
    @(negedge clk);
    rst_n = 1;
    drive(0, 0, 1, 1, 4'h7, 32'h50, 32'hB, 4'hF);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_pc", ex_pc, 32'h50);
    chk("post_rst_cmd", ex_exe_cmd, 4'h7);
    chk("post_rst_sr", sr, 4'h0);

`ifdef ID_EX_BUBBLE_CNT_EN
    rst_n = 0;
    #1;
    chk("cnt_reset", bubble_cnt, 0);
    rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 1, 0, 4'h1, 32'h60, 32'h1, 4'h0);
      @(posedge clk); @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 4'h1, 32'h60, 32'h1, 4'h0);
      @(posedge clk); @(negedge clk);
    end
    drive(0, 1, 0, 0, 4'h1, 32'h60, 32'h1, 4'h0);
    @(posedge clk); @(negedge clk);
    chk("cnt_seven", bubble_cnt, 16'd7);
    force dut.bubble_cnt_q = 16'hFFFF;
    #1 release dut.bubble_cnt_q;
    drive(1, 0, 1, 0, 4'h1, 32'h60, 32'h1, 4'h0);
    @(posedge clk); @(negedge clk);
    chk("cnt_saturate", bubble_cnt, 16'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

Pipeline register between decode and execute, holding every field the execute stage needs for one instruction. It also owns the 4-bit status register, stored as {Z,C,N,V}, which is written from the ALU's status output. It supplies the ALU with its 4-bit execute command, its operands and its carry-in. It supports stall (hold) and flush (bubble insertion) for hazard and branch control.

## Interface
Parameters:
- `DW`, 32: datapath width for PC and register values.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `stall`  in  1: hold all stage contents and the status register.
- `flush`  in  1: load a bubble instead of the decode inputs.
- `id_valid`, `id_wb_en`, `id_mem_r_en`, `id_mem_w_en`, `id_b`, `id_s`, `id_imm`  in  1 each: decode control bits.
- `id_exe_cmd`  in  4: ALU command.
- `id_pc`, `id_val_rn`, `id_val_rm`  in  DW each.
- `id_shift_operand`  in  12.
- `id_imm24`  in  24.
- `id_dest`  in  4.
- `ex_*`  out: registered copies of every `id_*` input above, same widths.
- `alu_sr`  in  4: ALU status {Z,C,N,V} for the instruction currently in EX.
- `sr`  out  4: architectural status register.
- `ex_carry`  out  1: equals `sr[2]`; drives the ALU carry input.

## Operation
Stage register, evaluated each `clk` edge in priority order:
- **Flush** (`flush`=1): load a bubble. `ex_valid`, `ex_wb_en`, `ex_mem_r_en`, `ex_mem_w_en`, `ex_b`, `ex_s` become 0 and `ex_exe_cmd` becomes 4'b0000. The data fields `ex_pc`, `ex_val_rn`, `ex_val_rm`, `ex_shift_operand`, `ex_imm24`, `ex_dest`, `ex_imm` also clear to 0.
- **Stall** (`stall`=1, `flush`=0): every `ex_*` holds its value.
- **Normal**: every `ex_*` loads its `id_*`.
- When `flush` and `stall` are both 1, flush wins.

Status register:
- **Write condition**: `sr` loads `alu_sr` on an edge where `ex_valid` & `ex_s` & ~`stall`, all sampled before that edge.
- The write is based on the instruction leaving EX, so it is independent of `flush`. A flush in the same cycle still commits the outgoing instruction's flags.
- **No write**: `sr` holds in all other cases, including bubbles and `ex_s`=0.
- A stalled S-instruction writes `sr` exactly once, on the edge where it finally advances.

Command handling:
- The stage does no decoding of `exe_cmd`. It passes all 16 codes through unchanged, including the unused ones.

## Timing
- **Latency**: an `id_*` value sampled at edge N appears on `ex_*` after edge N. This is one cycle.
- **Flag visibility**: an S-instruction in EX during cycle N updates `sr` and `ex_carry` at the end of cycle N. The next instruction in EX (cycle N+1) sees the new carry. There is no combinational path from `alu_sr` to `ex_carry`.
- **Reset**: asserting `rst_n`=0 clears all `ex_*` to 0, `sr` to 4'b0000 and `ex_carry` to 0 immediately, without waiting for a clock edge.
- **Reset release**: after deassertion, the first edge performs a normal load. Reset in the middle of a stall discards the held instruction.

## Configuration
Macro `ID_EX_BUBBLE_CNT_EN`.

When defined:
- Adds output `bubble_cnt` (16 bits, reset value 0).
- The counter increments on every edge where `flush`=1, or where `stall`=0 and `id_valid`=0.
- It saturates at 16'hFFFF and does not wrap.

When undefined:
- The port and the counter logic are absent.
- All other behaviour is identical.

## Test plan
- **Reset/load**: hold `rst_n`=0 mid-cycle, then check all outputs read 0 and `sr`=0. Release, drive `id_pc`=32'h10, `id_exe_cmd`=4'b0010, `id_valid`=1, then check `ex_pc`=32'h10 and `ex_exe_cmd`=4'b0010 one edge later.
- **Stall hold**: load `id_val_rn`=32'hA5A5A5A5, assert `stall` for 3 cycles while `id_val_rn` changes to 32'h1. Check `ex_val_rn` stays 32'hA5A5A5A5 until the first edge after `stall` drops.
- **Flush priority**: assert `flush`=1 and `stall`=1 with `id_wb_en`=1 and `id_exe_cmd`=4'b0100. Check `ex_valid`=0, `ex_wb_en`=0 and `ex_exe_cmd`=0.
- **Status write**: put an instruction in EX with `ex_s`=1 and drive `alu_sr`=4'b0100. Check `sr`=4'b0100 and `ex_carry`=1 after the edge. A following instruction with `ex_s`=0 and `alu_sr`=4'b1000 leaves `sr`=4'b0100.
- **Stalled S-instruction**: `ex_s`=1 with `stall`=1 for 2 cycles and `alu_sr`=4'b0001. Check `sr` unchanged until stall release, then `sr`=4'b0001. A bubble with `alu_sr`=4'b1111 leaves `sr` unchanged.
- **Counter** (with `ID_EX_BUBBLE_CNT_EN`): 5 flushes plus 2 loads with `id_valid`=0 give `bubble_cnt`=7. Preloaded via force to 16'hFFFF, one more flush leaves 16'hFFFF.
